// File: rtl/fir_controller.sv
// fir_controller: Moore sequencer for the 4-tap FIR datapath (register file + ALU).
// Revision 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module fir_controller (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       dr,
  input  logic       lc,
  input  logic       overflow,
  output logic       cnt_up,
  output logic       clear,
  output logic       modwait,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic       err
);

  localparam logic [2:0] C_OP_NOP   = 3'b000;
  localparam logic [2:0] C_OP_COPY  = 3'b001;
  localparam logic [2:0] C_OP_LOAD1 = 3'b010;
  localparam logic [2:0] C_OP_LOAD2 = 3'b011;
  localparam logic [2:0] C_OP_ADD   = 3'b100;
  localparam logic [2:0] C_OP_SUB   = 3'b101;
  localparam logic [2:0] C_OP_MUL   = 3'b110;

  typedef enum logic [4:0] {
    S_IDLE, S_LOADC, S_CWAIT, S_STORE, S_ZERO,
    S_SORT1, S_SORT2, S_SORT3, S_SORT4,
    S_MUL1, S_ADD1, S_MUL2, S_SUB2, S_MUL3, S_ADD3, S_MUL4, S_SUB4,
    S_EIDLE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] k_q, k_d;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE, S_EIDLE: begin
        if (dr)      state_d = S_STORE;
        else if (lc) state_d = S_LOADC;
      end
      S_LOADC: begin
        k_d     = k_q + 2'd1;
        state_d = S_CWAIT;
      end
      S_CWAIT: if (!lc) state_d = S_IDLE;
      S_STORE: state_d = S_ZERO;
      S_ZERO:  state_d = S_SORT1;
      S_SORT1: state_d = S_SORT2;
      S_SORT2: state_d = S_SORT3;
      S_SORT3: state_d = S_SORT4;
      S_SORT4: state_d = S_MUL1;
      // Only the arithmetic steps can overflow; any overflow abandons the sample.
      S_MUL1:  state_d = overflow ? S_EIDLE : S_ADD1;
      S_ADD1:  state_d = overflow ? S_EIDLE : S_MUL2;
      S_MUL2:  state_d = overflow ? S_EIDLE : S_SUB2;
      S_SUB2:  state_d = overflow ? S_EIDLE : S_MUL3;
      S_MUL3:  state_d = overflow ? S_EIDLE : S_ADD3;
      S_ADD3:  state_d = overflow ? S_EIDLE : S_MUL4;
      S_MUL4:  state_d = overflow ? S_EIDLE : S_SUB4;
      S_SUB4:  state_d = overflow ? S_EIDLE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_up  = 1'b0;
    clear   = 1'b0;
    modwait = 1'b1;
    err     = 1'b0;
    op      = C_OP_NOP;
    src1    = 4'd0;
    src2    = 4'd0;
    dest    = 4'd0;
    case (state_q)
      S_IDLE:  modwait = 1'b0;
      S_EIDLE: begin
        modwait = 1'b0;
        err     = 1'b1;
      end
      S_LOADC: begin
        op    = C_OP_LOAD2;
        dest  = 4'd7 + {2'b00, k_q};
        clear = (k_q == 2'd0);
      end
      S_CWAIT: ;
      S_STORE: begin
        op     = C_OP_LOAD1;
        dest   = 4'd5;
        cnt_up = 1'b1;
      end
      S_ZERO:  op = C_OP_SUB;
      S_SORT1: begin op = C_OP_COPY; src1 = 4'd2; dest = 4'd1; end
      S_SORT2: begin op = C_OP_COPY; src1 = 4'd3; dest = 4'd2; end
      S_SORT3: begin op = C_OP_COPY; src1 = 4'd4; dest = 4'd3; end
      S_SORT4: begin op = C_OP_COPY; src1 = 4'd5; dest = 4'd4; end
      S_MUL1:  begin op = C_OP_MUL; src1 = 4'd1; src2 = 4'd7;  dest = 4'd6; end
      S_ADD1:  begin op = C_OP_ADD; src2 = 4'd6; end
      S_MUL2:  begin op = C_OP_MUL; src1 = 4'd2; src2 = 4'd8;  dest = 4'd6; end
      S_SUB2:  begin op = C_OP_SUB; src2 = 4'd6; end
      S_MUL3:  begin op = C_OP_MUL; src1 = 4'd3; src2 = 4'd9;  dest = 4'd6; end
      S_ADD3:  begin op = C_OP_ADD; src2 = 4'd6; end
      S_MUL4:  begin op = C_OP_MUL; src1 = 4'd4; src2 = 4'd10; dest = 4'd6; end
      S_SUB4:  begin op = C_OP_SUB; src2 = 4'd6; end
      default: modwait = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_controller.sv
// tb_fir_controller: directed stimulus with a cycle-level reference model of the FIR sequencer.
`default_nettype none
`timescale 1ns/1ps

module tb_fir_controller;

  logic       clk = 1'b0;
  logic       n_reset, dr, lc, overflow;
  logic       cnt_up, clear, modwait, err;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;

  int n_vec = 0;
  int n_bad = 0;

  fir_controller dut (
    .clk(clk), .n_reset(n_reset), .dr(dr), .lc(lc), .overflow(overflow),
    .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .op(op),
    .src1(src1), .src2(src2), .dest(dest), .err(err)
  );

  always #5 clk = ~clk;

  // Model: mode 0 waiting, 1 coefficient write, 2 coefficient hold, 3 sample step m_step.
  int m_mode = 0;
  int m_step = 0;
  int m_k    = 0;
  bit m_err  = 1'b0;

  // One sample-sequence step as {op, src1, src2, dest}.
  function automatic logic [14:0] step_row(input int s);
    case (s)
      1:  return {3'b010, 4'd0, 4'd0,  4'd5};
      2:  return {3'b101, 4'd0, 4'd0,  4'd0};
      3:  return {3'b001, 4'd2, 4'd0,  4'd1};
      4:  return {3'b001, 4'd3, 4'd0,  4'd2};
      5:  return {3'b001, 4'd4, 4'd0,  4'd3};
      6:  return {3'b001, 4'd5, 4'd0,  4'd4};
      7:  return {3'b110, 4'd1, 4'd7,  4'd6};
      8:  return {3'b100, 4'd0, 4'd6,  4'd0};
      9:  return {3'b110, 4'd2, 4'd8,  4'd6};
      10: return {3'b101, 4'd0, 4'd6,  4'd0};
      11: return {3'b110, 4'd3, 4'd9,  4'd6};
      12: return {3'b100, 4'd0, 4'd6,  4'd0};
      13: return {3'b110, 4'd4, 4'd10, 4'd6};
      default: return {3'b101, 4'd0, 4'd6, 4'd0};
    endcase
  endfunction

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_mode <= 0; m_step <= 0; m_k <= 0; m_err <= 1'b0;
    end else begin
      case (m_mode)
        0: if (dr) begin
             m_mode <= 3; m_step <= 1; m_err <= 1'b0;
           end else if (lc) begin
             m_mode <= 1; m_err <= 1'b0;
           end
        1: begin m_mode <= 2; m_k <= (m_k + 1) % 4; end
        2: if (!lc) m_mode <= 0;
        default: begin
          if (m_step >= 7 && overflow) begin
            m_mode <= 0; m_err <= 1'b1;
          end else if (m_step == 14) m_mode <= 0;
          else m_step <= m_step + 1;
        end
      endcase
    end
  end

  // {cnt_up, clear, modwait, op, src1, src2, dest, err}
  function automatic logic [18:0] model_out();
    logic [14:0] row;
    case (m_mode)
      0: return {3'b000, 15'd0, m_err};
      1: begin
        row = {3'b011, 4'd0, 4'd0, 4'(7 + m_k)};
        return {1'b0, (m_k == 0), 1'b1, row, 1'b0};
      end
      2: return {3'b001, 15'd0, 1'b0};
      default: return {(m_step == 1), 1'b0, 1'b1, step_row(m_step), 1'b0};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [18:0] act, exp_v;
    act   = {cnt_up, clear, modwait, op, src1, src2, dest, err};
    exp_v = model_out();
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_compare t=%0t: got %b expected %b", $time, act, exp_v);
    end
  end

  // Event recorders for the directed checks.
  int q_dest[$];
  int n_clr = 0, n_mw = 0, n_cu = 0, n_mul2 = 0, n_load2 = 0;
  always @(negedge clk) begin
    if (op == 3'b011) begin q_dest.push_back(int'(dest)); n_load2++; end
    if (clear)   n_clr++;
    if (modwait) n_mw++;
    if (cnt_up)  n_cu++;
    if (op == 3'b110 && src1 == 4'd2) n_mul2++;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic lc_pulse();
    @(negedge clk);
    lc = 1'b1;
    #12.5 lc = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic run_sample(input logic [13:0] mask, input bit with_lc);
    bit abandoned = 1'b0;
    @(negedge clk);
    dr = 1'b1;
    lc = with_lc;
    @(negedge clk);
    dr = 1'b0;
    lc = 1'b0;
    for (int s = 1; s <= 14; s++) begin
      overflow = mask[s-1] & ~abandoned;
      @(negedge clk);
      if (mask[s-1] && s >= 7 && !abandoned) begin
        abandoned = 1'b1;
        chk("abandon_err", int'(err), 1);
        chk("abandon_modwait", int'(modwait), 0);
        chk("abandon_op", int'(op), 0);
      end
    end
    overflow = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int mw0, cu0, ld0;
    n_reset = 1'b1; dr = 1'b0; lc = 1'b0; overflow = 1'b0;
    #1 n_reset = 1'b0;
    #1;
    chk("reset_op", int'(op), 0);
    chk("reset_modwait_err", int'({modwait, err, cnt_up, clear}), 0);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;

    // Coefficient load: four pulses then a wrap.
    for (int i = 0; i < 4; i++) lc_pulse();
    chk("coef_count", q_dest.size(), 4);
    for (int i = 0; i < 4; i++) chk("coef_dest", q_dest[i], 7 + i);
    chk("coef_clear", n_clr, 1);
    chk("coef_modwait", n_mw, 8);
    lc_pulse();
    chk("coef_wrap_dest", q_dest[4], 7);
    chk("coef_wrap_clear", n_clr, 2);

    // Clean sample with literal pins on the first, eighth and last steps.
    mw0 = n_mw; cu0 = n_cu;
    @(negedge clk);
    dr = 1'b1;
    @(negedge clk);
    dr = 1'b0;
    for (int s = 1; s <= 14; s++) begin
      if (s == 1)  chk("s1_store", int'({op, dest, cnt_up}), {3'b010, 4'd5, 1'b1});
      if (s == 8)  chk("s8_add1", int'({op, src1, src2, dest}), {3'b100, 4'd0, 4'd6, 4'd0});
      if (s == 14) chk("s14_sub4", int'({op, src1, src2, dest}), {3'b101, 4'd0, 4'd6, 4'd0});
      @(negedge clk);
    end
    #1;
    chk("sample_modwait_cycles", n_mw - mw0, 14);
    chk("sample_cnt_up", n_cu - cu0, 1);
    chk("sample_idle_after", int'({modwait, op, err}), 0);

    // Overflow in ADD1, then a full recovery sequence.
    n_mul2 = 0;
    run_sample(14'b00000010000000, 1'b0);
    chk("ovf_no_mul2", n_mul2, 0);
    mw0 = n_mw;
    run_sample(14'd0, 1'b0);
    chk("recover_modwait_cycles", n_mw - mw0, 14);

    // Overflow only while it must be ignored.
    mw0 = n_mw;
    run_sample(14'b00000000111110, 1'b0);
    chk("ignored_ovf_cycles", n_mw - mw0, 14);

    // dr and lc together: sample wins, k stays at 1.
    ld0 = n_load2;
    run_sample(14'd0, 1'b1);
    chk("both_no_load2", n_load2 - ld0, 0);
    lc_pulse();
    chk("both_later_dest", q_dest[q_dest.size()-1], 8);

    // Asynchronous reset mid-sequence.
    @(negedge clk);
    dr = 1'b1;
    @(negedge clk);
    dr = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_mul3", int'({op, src1}), {3'b110, 4'd3});
    #1 n_reset = 1'b0;
    #1;
    chk("async_reset_outs", int'({modwait, op, err}), 0);
    @(negedge clk);
    n_reset = 1'b1;
    mw0 = n_clr;
    lc_pulse();
    chk("post_reset_dest", q_dest[q_dest.size()-1], 7);
    chk("post_reset_clear", n_clr - mw0, 1);

    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
